pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the five-stage in-order core. It watches the decode stage (rs indices/enables, jump/branch resolution, trap instructions) and the downstream pipeline registers (destination indices, long-latency producers). From these it generates per-stage stall and flush controls. It sequences three things: load/CSR-use bubbles, ID-resolved redirects, and the drain-then-redirect sequence for ecall/ebreak/mret. It sits beside `id_top` and drives the enables of pc, if2id, id2ex, ex2mem and mem2wb.

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the five-stage in-order core.
// It detects load/CSR-use hazards at decode, issues decode-resolved jump/branch
// redirects, runs the drain-then-redirect sequence for ecall/ebreak/mret, and
// discards a fetch that was still outstanding when the pc was redirected.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pipe_ctrl_id_valid_i,
  input  logic       pipe_ctrl_id_rs1_en_i,
  input  logic       pipe_ctrl_id_rs2_en_i,
  input  logic [4:0] pipe_ctrl_id_rs1_index_i,
  input  logic [4:0] pipe_ctrl_id_rs2_index_i,
  input  logic       pipe_ctrl_id_trap_i,
  input  logic       pipe_ctrl_jumpbranch_en_i,
  input  logic       pipe_ctrl_id2ex_rd_en_i,
  input  logic [4:0] pipe_ctrl_id2ex_rd_index_i,
  input  logic       pipe_ctrl_id2ex_long_i,
  input  logic       pipe_ctrl_ex2mem_rd_en_i,
  input  logic [4:0] pipe_ctrl_ex2mem_rd_index_i,
  input  logic       pipe_ctrl_ex2mem_long_i,
  input  logic       pipe_ctrl_if_busy_i,
  input  logic       pipe_ctrl_mem_busy_i,
  output logic       pipe_ctrl_pc_stall_o,
  output logic       pipe_ctrl_if2id_stall_o,
  output logic       pipe_ctrl_if2id_flush_o,
  output logic       pipe_ctrl_id2ex_stall_o,
  output logic       pipe_ctrl_id2ex_flush_o,
  output logic       pipe_ctrl_ex2mem_stall_o,
  output logic       pipe_ctrl_mem2wb_stall_o,
  output logic       pipe_ctrl_redirect_o,
  output logic       pipe_ctrl_trap_redirect_o,
  output logic       pipe_ctrl_busy_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [2:0] DRAIN_INIT  = 3'(DRAIN_CYCLES);

  logic [1:0] state_r, state_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  logic       kill_pending_r, kill_pending_nxt_s;
  logic       hz_1_s, hz_2_s, load_use_s;
  logic       bubble_s, kill_set_s, kill_clr_s;

  // A source register depends on a long-latency producer still in EX or MEM.
  // x0 never creates a dependency; short producers are covered by forwarding.
  function automatic logic src_hazard(
    input logic       en,
    input logic [4:0] idx,
    input logic       ex_en,
    input logic [4:0] ex_idx,
    input logic       ex_long,
    input logic       mem_en,
    input logic [4:0] mem_idx,
    input logic       mem_long
  );
    return en && (idx != 5'd0) &&
           ((ex_en && ex_long && (idx == ex_idx)) ||
            (mem_en && mem_long && (idx == mem_idx)));
  endfunction

  // Load/CSR-use detection on both decode operands.
  always_comb begin
    hz_1_s = pipe_ctrl_id_valid_i &&
             src_hazard(pipe_ctrl_id_rs1_en_i, pipe_ctrl_id_rs1_index_i,
                        pipe_ctrl_id2ex_rd_en_i, pipe_ctrl_id2ex_rd_index_i, pipe_ctrl_id2ex_long_i,
                        pipe_ctrl_ex2mem_rd_en_i, pipe_ctrl_ex2mem_rd_index_i, pipe_ctrl_ex2mem_long_i);
    hz_2_s = pipe_ctrl_id_valid_i &&
             src_hazard(pipe_ctrl_id_rs2_en_i, pipe_ctrl_id_rs2_index_i,
                        pipe_ctrl_id2ex_rd_en_i, pipe_ctrl_id2ex_rd_index_i, pipe_ctrl_id2ex_long_i,
                        pipe_ctrl_ex2mem_rd_en_i, pipe_ctrl_ex2mem_rd_index_i, pipe_ctrl_ex2mem_long_i);
    load_use_s = hz_1_s | hz_2_s;
  end

  // Prioritised stall/flush generation plus next-state for the trap FSM and fetch kill.
  always_comb begin
    pipe_ctrl_pc_stall_o      = 1'b0;
    pipe_ctrl_if2id_stall_o   = 1'b0;
    pipe_ctrl_if2id_flush_o   = 1'b0;
    pipe_ctrl_id2ex_stall_o   = 1'b0;
    pipe_ctrl_id2ex_flush_o   = 1'b0;
    pipe_ctrl_ex2mem_stall_o  = 1'b0;
    pipe_ctrl_mem2wb_stall_o  = 1'b0;
    pipe_ctrl_redirect_o      = 1'b0;
    pipe_ctrl_trap_redirect_o = 1'b0;
    state_nxt_s               = state_r;
    cnt_nxt_s                 = cnt_r;
    kill_pending_nxt_s        = kill_pending_r;
    bubble_s                  = 1'b0;
    kill_set_s                = 1'b0;
    kill_clr_s                = 1'b0;

    if (pipe_ctrl_mem_busy_i) begin
      // Freeze the whole pipe; FSM, counter and kill flag keep their values.
      pipe_ctrl_pc_stall_o     = 1'b1;
      pipe_ctrl_if2id_stall_o  = 1'b1;
      pipe_ctrl_id2ex_stall_o  = 1'b1;
      pipe_ctrl_ex2mem_stall_o = 1'b1;
      pipe_ctrl_mem2wb_stall_o = 1'b1;
    end else begin
      case (state_r)
        ST_DRAIN: begin
          pipe_ctrl_pc_stall_o    = 1'b1;
          pipe_ctrl_if2id_stall_o = 1'b1;
          pipe_ctrl_id2ex_flush_o = 1'b1;
          cnt_nxt_s               = cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            state_nxt_s = ST_REDIRECT;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_REDIRECT: begin
          pipe_ctrl_trap_redirect_o = 1'b1;
          pipe_ctrl_if2id_flush_o   = 1'b1;
          state_nxt_s               = ST_IDLE;
        end
        ST_IDLE: begin
          if (load_use_s) begin
            // Branches and traps in ID wait until their operands are ready.
            pipe_ctrl_pc_stall_o    = 1'b1;
            pipe_ctrl_if2id_stall_o = 1'b1;
            pipe_ctrl_id2ex_flush_o = 1'b1;
          end else if (pipe_ctrl_id_valid_i && pipe_ctrl_id_trap_i) begin
            // The trap itself moves on to EX; younger fetches are discarded.
            pipe_ctrl_pc_stall_o    = 1'b1;
            pipe_ctrl_if2id_flush_o = 1'b1;
            state_nxt_s             = ST_DRAIN;
            cnt_nxt_s               = DRAIN_INIT;
          end else if (pipe_ctrl_id_valid_i && pipe_ctrl_jumpbranch_en_i) begin
            pipe_ctrl_redirect_o    = 1'b1;
            pipe_ctrl_if2id_flush_o = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 3'd0;
        end
      endcase

      // An outstanding fetch leaves a bubble in ID; a redirecting pc must not be held.
      bubble_s = pipe_ctrl_if_busy_i && !pipe_ctrl_if2id_stall_o &&
                 !pipe_ctrl_redirect_o && !pipe_ctrl_trap_redirect_o;
      pipe_ctrl_pc_stall_o = pipe_ctrl_pc_stall_o | bubble_s;

      // The fetch in flight at a redirect is wrong-path: flush it when it returns.
      kill_set_s = (pipe_ctrl_redirect_o | pipe_ctrl_trap_redirect_o) & pipe_ctrl_if_busy_i;
      kill_clr_s = kill_pending_r & !pipe_ctrl_if_busy_i;
      pipe_ctrl_if2id_flush_o = pipe_ctrl_if2id_flush_o | bubble_s | kill_clr_s;
      kill_pending_nxt_s      = kill_set_s | (kill_pending_r & !kill_clr_s);
    end
  end

  assign pipe_ctrl_busy_o = (state_r != ST_IDLE);

  // Trap FSM, drain counter and fetch-kill flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 3'd0;
      kill_pending_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      kill_pending_r <= kill_pending_nxt_s;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (DRAIN_CYCLES = 3).
// Output vector bit order: pc_stall, if2id_stall, if2id_flush, id2ex_stall,
// id2ex_flush, ex2mem_stall, mem2wb_stall, redirect, trap_redirect, busy.
module tb_pipe_hazard_ctrl;

  localparam logic [9:0] NONE      = 10'b0000000000;
  localparam logic [9:0] LU        = 10'b1100100000;
  localparam logic [9:0] ALLST     = 10'b1101011000;
  localparam logic [9:0] ALLST_B   = 10'b1101011001;
  localparam logic [9:0] DRN       = 10'b1100100001;
  localparam logic [9:0] TRAPIN    = 10'b1010000000;
  localparam logic [9:0] TREDIR    = 10'b0010000011;
  localparam logic [9:0] JB        = 10'b0010000100;
  localparam logic [9:0] IFBUBBLE  = 10'b1010000000;
  localparam logic [9:0] KILL      = 10'b0010000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, rs1_en, rs2_en, trap, jb;
  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic       ex_en, ex_long, mem_en, mem_long, if_busy, mem_busy;
  logic       pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush;
  logic       ex2mem_stall, mem2wb_stall, redirect, trap_redirect, busy;
  logic [9:0] outv, e;
  int         ncmp = 0;
  int         nerr = 0;

  assign outv = {pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush,
                 ex2mem_stall, mem2wb_stall, redirect, trap_redirect, busy};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .pipe_ctrl_id_valid_i(valid),
    .pipe_ctrl_id_rs1_en_i(rs1_en), .pipe_ctrl_id_rs2_en_i(rs2_en),
    .pipe_ctrl_id_rs1_index_i(rs1), .pipe_ctrl_id_rs2_index_i(rs2),
    .pipe_ctrl_id_trap_i(trap), .pipe_ctrl_jumpbranch_en_i(jb),
    .pipe_ctrl_id2ex_rd_en_i(ex_en), .pipe_ctrl_id2ex_rd_index_i(ex_rd), .pipe_ctrl_id2ex_long_i(ex_long),
    .pipe_ctrl_ex2mem_rd_en_i(mem_en), .pipe_ctrl_ex2mem_rd_index_i(mem_rd), .pipe_ctrl_ex2mem_long_i(mem_long),
    .pipe_ctrl_if_busy_i(if_busy), .pipe_ctrl_mem_busy_i(mem_busy),
    .pipe_ctrl_pc_stall_o(pc_stall),
    .pipe_ctrl_if2id_stall_o(if2id_stall), .pipe_ctrl_if2id_flush_o(if2id_flush),
    .pipe_ctrl_id2ex_stall_o(id2ex_stall), .pipe_ctrl_id2ex_flush_o(id2ex_flush),
    .pipe_ctrl_ex2mem_stall_o(ex2mem_stall), .pipe_ctrl_mem2wb_stall_o(mem2wb_stall),
    .pipe_ctrl_redirect_o(redirect), .pipe_ctrl_trap_redirect_o(trap_redirect),
    .pipe_ctrl_busy_o(busy)
  );

  task automatic clr();
    valid = 1'b0; rs1_en = 1'b0; rs2_en = 1'b0; trap = 1'b0; jb = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    ex_en = 1'b0; ex_long = 1'b0; mem_en = 1'b0; mem_long = 1'b0;
    if_busy = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr(); rst = 1'b1;
    tick(); tick();
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL reset_hold: got %b want %b", outv, e); end
    tick(); rst = 1'b0; tick();
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL reset_release: got %b want %b", outv, e); end
    tick();
  endtask

  task automatic test_load_use();
    // Producer in EX: two bubbles as it walks EX -> MEM.
    clr(); valid = 1'b1; rs1_en = 1'b1; rs1 = 5'd5; ex_en = 1'b1; ex_rd = 5'd5; ex_long = 1'b1;
    e = LU; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL lu_ex_1: got %b want %b", outv, e); end
    tick(); ex_en = 1'b0; mem_en = 1'b1; mem_rd = 5'd5; mem_long = 1'b1;
    e = LU; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL lu_ex_2: got %b want %b", outv, e); end
    tick(); mem_en = 1'b0;
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL lu_ex_done: got %b want %b", outv, e); end
    // Producer already in MEM: one bubble.
    tick(); mem_en = 1'b1; mem_rd = 5'd5; mem_long = 1'b1;
    e = LU; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL lu_mem_1: got %b want %b", outv, e); end
    tick(); mem_en = 1'b0;
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL lu_mem_done: got %b want %b", outv, e); end
    // rs2 hazard, plus a taken branch that must be deferred.
    tick(); clr(); valid = 1'b1; rs2_en = 1'b1; rs2 = 5'd7; jb = 1'b1;
    ex_en = 1'b1; ex_rd = 5'd7; ex_long = 1'b1;
    e = LU; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL lu_rs2_jb: got %b want %b", outv, e); end
    // A mem_busy cycle stretches the stall.
    tick(); mem_busy = 1'b1;
    e = ALLST; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL lu_memstretch: got %b want %b", outv, e); end
    tick(); mem_busy = 1'b0;
    e = LU; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL lu_after_stretch: got %b want %b", outv, e); end
    tick(); clr(); tick();
  endtask

  task automatic test_forward();
    clr(); valid = 1'b1; rs1_en = 1'b1; rs1 = 5'd5; ex_en = 1'b1; ex_rd = 5'd5; ex_long = 1'b0;
    mem_en = 1'b1; mem_rd = 5'd5; mem_long = 1'b0;
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL fwd_short: got %b want %b", outv, e); end
    tick(); rs1 = 5'd0; ex_rd = 5'd0; ex_long = 1'b1; mem_en = 1'b0;
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL fwd_x0: got %b want %b", outv, e); end
    tick(); rs1 = 5'd9; ex_rd = 5'd9; rs1_en = 1'b0;
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL fwd_rs_dis: got %b want %b", outv, e); end
    tick(); rs1_en = 1'b1; valid = 1'b0; trap = 1'b1; jb = 1'b1;
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL fwd_invalid: got %b want %b", outv, e); end
    tick(); clr(); tick();
  endtask

  task automatic test_trap();
    logic [9:0] seq [0:5];
    logic [9:0] seq_mb [0:7];
    seq = '{TRAPIN, DRN, DRN, DRN, TREDIR, NONE};
    seq_mb = '{TRAPIN, DRN, ALLST_B, ALLST_B, DRN, DRN, TREDIR, NONE};
    // Plain drain; a jump presented during DRAIN must be ignored.
    clr(); valid = 1'b1; trap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = seq[i]; #2; ncmp++;
      if (outv !== e) begin nerr++; $display("FAIL trap_c%0d: got %b want %b", i, outv, e); end
      tick(); clr();
      if (i == 1) begin valid = 1'b1; jb = 1'b1; end
    end
    // Two mem_busy cycles mid-DRAIN push trap_redirect to T+6.
    clr(); valid = 1'b1; trap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = seq_mb[i]; #2; ncmp++;
      if (outv !== e) begin nerr++; $display("FAIL trap_mb_c%0d: got %b want %b", i, outv, e); end
      tick(); clr();
      if (i == 1 || i == 2) mem_busy = 1'b1;
    end
    // Load-use beats the trap; the trap is taken once the hazard clears.
    clr(); valid = 1'b1; trap = 1'b1; rs1_en = 1'b1; rs1 = 5'd3; ex_en = 1'b1; ex_rd = 5'd3; ex_long = 1'b1;
    e = LU; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL trap_lu_0: got %b want %b", outv, e); end
    tick(); ex_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = seq[i]; #2; ncmp++;
      if (outv !== e) begin nerr++; $display("FAIL trap_lu_c%0d: got %b want %b", i + 1, outv, e); end
      tick(); clr();
    end
  endtask

  task automatic test_redirect_if_busy();
    clr(); valid = 1'b1; jb = 1'b1; if_busy = 1'b1;
    #2; ncmp++;
    if ({redirect, if2id_flush, trap_redirect} !== 3'b110) begin
      nerr++; $display("FAIL rdr_busy_0: got %b want 110", {redirect, if2id_flush, trap_redirect});
    end
    tick(); valid = 1'b0; jb = 1'b0;
    for (int i = 1; i < 3; i++) begin
      e = IFBUBBLE; #2; ncmp++;
      if (outv !== e) begin nerr++; $display("FAIL rdr_busy_%0d: got %b want %b", i, outv, e); end
      tick();
    end
    if_busy = 1'b0;
    e = KILL; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rdr_kill: got %b want %b", outv, e); end
    tick();
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rdr_kill_clear: got %b want %b", outv, e); end
    // Redirect with fetch idle: no later kill flush.
    tick(); valid = 1'b1; jb = 1'b1;
    e = JB; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rdr_idle: got %b want %b", outv, e); end
    tick(); clr();
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rdr_idle_after: got %b want %b", outv, e); end
    tick();
  endtask

  task automatic test_mem_busy_priority();
    clr(); valid = 1'b1; jb = 1'b1; rs1_en = 1'b1; rs1 = 5'd4;
    ex_en = 1'b1; ex_rd = 5'd4; ex_long = 1'b1; mem_busy = 1'b1;
    e = ALLST; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL mb_prio: got %b want %b", outv, e); end
    tick(); mem_busy = 1'b0; ex_en = 1'b0;
    e = JB; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL mb_release_jb: got %b want %b", outv, e); end
    tick(); clr(); tick();
  endtask

  task automatic test_reset_mid_drain();
    clr(); valid = 1'b1; trap = 1'b1;
    e = TRAPIN; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rstd_trap: got %b want %b", outv, e); end
    tick(); clr(); tick();
    e = DRN; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rstd_drain_cnt2: got %b want %b", outv, e); end
    rst = 1'b1; #1;
    e = NONE; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rstd_async: got %b want %b", outv, e); end
    tick(); tick(); rst = 1'b0;
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rstd_idle: got %b want %b", outv, e); end
    tick(); valid = 1'b1; trap = 1'b1;
    e = TRAPIN; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rstd_restart: got %b want %b", outv, e); end
    tick(); clr();
    e = DRN; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rstd_restart_drain: got %b want %b", outv, e); end
    tick(); tick(); tick(); tick();
    e = NONE; #2; ncmp++;
    if (outv !== e) begin nerr++; $display("FAIL rstd_final_idle: got %b want %b", outv, e); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_trap();
    test_redirect_if_busy();
    test_mem_busy_priority();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
